mem_arbiter: RTL and testbench

Two-requester arbiter for the shared memory port. Requester A (instruction fetch) and requester B (data load/store) each issue single-word transactions. The block grants one requester at a time and steers the shared address, write-enable and write-data lines through a `mux` instance. It waits for the memory handshake, returns read data to the owner, and bounds each access with a timeout.

---
 rtl/mem_arbiter_pkg.sv | 34 +++
 rtl/mem_arbiter_mux.sv | 15 +
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arbiter_pkg;

    localparam int WORD                = 16;
    localparam int ARB_TIMEOUT_DEFAULT = 15;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    // A lone requester wins outright; on a tie the loser of the last round goes next.
    function automatic owner_t pick_winner(input logic a_req,
                                           input logic b_req,
                                           input owner_t last_winner);
        owner_t w;
        if (a_req && b_req) begin
            w = (last_winner == OWNER_A) ? OWNER_B : OWNER_A;
        end else if (a_req) begin
            w = OWNER_A;
        end else begin
            w = OWNER_B;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_arbiter_mux.sv
// Two-way word mux steering the owner's {addr, we, wdata} onto the memory port.
// Latency: combinational.
// Backpressure: none; follows sel immediately.
module mux #(
    parameter int W = 1
) (
    input  logic         sel,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    output logic [W-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting requester A or B single-word access to one memory port.
// Latency: grant 1 cycle after req, done 1 cycle after mem_ready (min 2 req-to-done), timeout after TIMEOUT wait cycles.
// Backpressure: requesters hold req until done; the memory stalls the owner by withholding mem_ready.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = ARB_TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 a_req,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic                 a_we,
    input  logic [WORD-1:0]      a_wdata,
    output logic                 a_gnt,
    output logic                 a_done,
    output logic [WORD-1:0]      a_rdata,

    input  logic                 b_req,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic                 b_we,
    input  logic [WORD-1:0]      b_wdata,
    output logic                 b_gnt,
    output logic                 b_done,
    output logic [WORD-1:0]      b_rdata,

    output logic                 err,

    output logic                 mem_sel,
    output logic                 mem_en,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_we,
    output logic [WORD-1:0]      mem_wdata,
    input  logic                 mem_ready,
    input  logic [WORD-1:0]      mem_rdata
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam int               MUX_W    = ADDR_SIZE + 1 + WORD;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       state;
    owner_t           owner;
    owner_t           last_winner;
    owner_t           winner;
    logic [CNT_W-1:0] cnt;
    logic [MUX_W-1:0] mux_out;
    logic             mux_we;

    assign winner  = pick_winner(a_req, b_req, last_winner);
    assign mem_sel = (owner == OWNER_B);

    mux #(
        .W   (MUX_W)
    ) u_mux (
        .sel (mem_sel),
        .in0 ({a_addr, a_we, a_wdata}),
        .in1 ({b_addr, b_we, b_wdata}),
        .out (mux_out)
    );

    assign {mem_addr, mux_we, mem_wdata} = mux_out;
    // Address and data may float between accesses, but a write strobe must never leak out.
    assign mem_we = mux_we & mem_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            owner       <= OWNER_A;
            last_winner <= OWNER_B;
            cnt         <= '0;
            a_gnt       <= 1'b0;
            b_gnt       <= 1'b0;
            a_done      <= 1'b0;
            b_done      <= 1'b0;
            err         <= 1'b0;
            mem_en      <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
        end else begin
            a_done <= 1'b0;
            b_done <= 1'b0;
            err    <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (a_req || b_req) begin
                        state       <= ARB_ACCESS;
                        owner       <= winner;
                        last_winner <= winner;
                        cnt         <= '0;
                        mem_en      <= 1'b1;
                        a_gnt       <= (winner == OWNER_A);
                        b_gnt       <= (winner == OWNER_B);
                    end
                end
                ARB_ACCESS: begin
                    // mem_ready is tested first so a completion on the last allowed cycle still succeeds.
                    if (mem_ready || cnt == CNT_LAST) begin
                        state  <= ARB_IDLE;
                        mem_en <= 1'b0;
                        a_gnt  <= 1'b0;
                        b_gnt  <= 1'b0;
                        err    <= ~mem_ready;
                        if (owner == OWNER_A) begin
                            a_done  <= 1'b1;
                            a_rdata <= mem_ready ? mem_rdata : '0;
                        end else begin
                            b_done  <= 1'b1;
                            b_rdata <= mem_ready ? mem_rdata : '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model checked every cycle.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW  = 8;
    localparam int TMO = 4;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic            a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0]   a_addr = '0, b_addr = '0;
    logic [WORD-1:0] a_wdata = '0, b_wdata = '0;
    logic            mem_ready = 1'b0;
    logic [WORD-1:0] mem_rdata = '0;

    logic            a_gnt, a_done, b_gnt, b_done, err;
    logic [WORD-1:0] a_rdata, b_rdata, mem_wdata;
    logic            mem_sel, mem_en, mem_we;
    logic [AW-1:0]   mem_addr;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(
        .ADDR_SIZE (AW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_addr    (a_addr),
        .a_we      (a_we),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_done    (a_done),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_addr    (b_addr),
        .b_we      (b_we),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_done    (b_done),
        .b_rdata   (b_rdata),
        .err       (err),
        .mem_sel   (mem_sel),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an access is either in flight (owner, cycles spent) or not.
    bit              m_busy = 1'b0;
    int              m_own  = 0;
    int              m_last = 1;
    int              m_cyc  = 0;
    bit              m_a_done = 1'b0, m_b_done = 1'b0, m_err = 1'b0;
    logic [WORD-1:0] m_a_rd = '0, m_b_rd = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_own = 0; m_last = 1; m_cyc = 0;
            m_a_done = 1'b0; m_b_done = 1'b0; m_err = 1'b0;
            m_a_rd = '0; m_b_rd = '0;
        end else begin
            m_a_done = 1'b0; m_b_done = 1'b0; m_err = 1'b0;
            if (m_busy) begin
                m_cyc++;
                if (mem_ready || m_cyc == TMO) begin
                    if (m_own == 0) begin
                        m_a_done = 1'b1;
                        m_a_rd   = mem_ready ? mem_rdata : '0;
                    end else begin
                        m_b_done = 1'b1;
                        m_b_rd   = mem_ready ? mem_rdata : '0;
                    end
                    m_err  = !mem_ready;
                    m_busy = 1'b0;
                end
            end else if (a_req || b_req) begin
                m_own  = (a_req && b_req) ? 1 - m_last : (a_req ? 0 : 1);
                m_last = m_own;
                m_busy = 1'b1;
                m_cyc  = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("a_gnt",     32'(a_gnt),     32'(m_busy && m_own == 0));
        check("b_gnt",     32'(b_gnt),     32'(m_busy && m_own == 1));
        check("a_done",    32'(a_done),    32'(m_a_done));
        check("b_done",    32'(b_done),    32'(m_b_done));
        check("err",       32'(err),       32'(m_err));
        check("a_rdata",   32'(a_rdata),   32'(m_a_rd));
        check("b_rdata",   32'(b_rdata),   32'(m_b_rd));
        check("mem_sel",   32'(mem_sel),   32'(m_own == 1));
        check("mem_en",    32'(mem_en),    32'(m_busy));
        check("mem_addr",  32'(mem_addr),  32'((m_own == 1) ? b_addr : a_addr));
        check("mem_we",    32'(mem_we),    32'(m_busy && ((m_own == 1) ? b_we : a_we)));
        check("mem_wdata", 32'(mem_wdata), 32'((m_own == 1) ? b_wdata : a_wdata));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Issues one access and returns the tick (1 = edge that samples req) at which done was seen.
    task automatic run_access(input bit use_b, input logic [AW-1:0] addr, input logic we,
                              input logic [WORD-1:0] wdata, input int wait_cyc,
                              input logic [WORD-1:0] rd, output int done_at,
                              output logic err_at, output logic [WORD-1:0] rdata_at);
        done_at  = -1;
        err_at   = 1'b0;
        rdata_at = '0;
        if (use_b) begin
            b_req = 1'b1; b_addr = addr; b_we = we; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_addr = addr; a_we = we; a_wdata = wdata;
        end
        for (int t = 1; t <= 40 && done_at < 0; t++) begin
            tick();
            if (use_b ? b_done : a_done) begin
                done_at  = t;
                err_at   = err;
                rdata_at = use_b ? b_rdata : a_rdata;
            end else begin
                if (use_b ? b_gnt : a_gnt) begin
                    check("acc_mem_sel",  32'(mem_sel),  32'(use_b));
                    check("acc_mem_addr", 32'(mem_addr), 32'(addr));
                    check("acc_mem_we",   32'(mem_we),   32'(we));
                    check("acc_wdata",    32'(mem_wdata), 32'(wdata));
                end
                if (wait_cyc >= 0 && t == wait_cyc + 1) begin
                    mem_ready = 1'b1;
                    mem_rdata = rd;
                end
            end
        end
        a_req = 1'b0; b_req = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: summary not reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int              d;
        logic            e;
        logic [WORD-1:0] r;
        int              g[8];
        int              g_exp[8];

        g_exp = '{1, 0, 2, 0, 1, 0, 2, 0};
        #1 rst_n = 1'b0;
        tick();
        tick();
        check("rst_a_gnt",   32'(a_gnt),   32'h0);
        check("rst_mem_en",  32'(mem_en),  32'h0);
        check("rst_mem_we",  32'(mem_we),  32'h0);
        check("rst_a_rdata", 32'(a_rdata), 32'h0);
        rst_n = 1'b1;

        // Single zero-wait read from A
        run_access(1'b0, 8'h12, 1'b0, 16'h0, 0, 16'h00AB, d, e, r);
        check("a_read_latency", 32'(d), 32'd2);
        check("a_read_err",     32'(e), 32'h0);
        check("a_read_rdata",   32'(r), 32'h00AB);
        check("a_read_b_rdata", 32'(b_rdata), 32'h0);
        tick();
        check("a_done_one_cycle", 32'(a_done), 32'h0);

        // Tie out of reset, both held, zero wait: A, B, A, B
        do_reset();
        a_req = 1'b1; a_addr = 8'h21; a_we = 1'b0;
        b_req = 1'b1; b_addr = 8'h31; b_we = 1'b0;
        mem_ready = 1'b1; mem_rdata = 16'hC0DE;
        for (int t = 0; t < 8; t++) begin
            tick();
            g[t] = a_gnt ? 1 : (b_gnt ? 2 : 0);
        end
        a_req = 1'b0; b_req = 1'b0; mem_ready = 1'b0;
        for (int t = 0; t < 8; t++) check("rr_grant_seq", 32'(g[t]), 32'(g_exp[t]));

        // B write with three wait cycles
        run_access(1'b1, 8'h40, 1'b1, 16'h5A5A, 3, 16'hFFFF, d, e, r);
        check("b_write_done_at", 32'(d), 32'd5);
        check("b_write_err",     32'(e), 32'h0);
        check("b_write_rdata",   32'(r), 32'hFFFF);

        // Timeout with no mem_ready
        run_access(1'b0, 8'h77, 1'b0, 16'h0, -1, 16'h0, d, e, r);
        check("tmo_done_at", 32'(d), 32'(TMO + 1));
        check("tmo_err",     32'(e), 32'h1);
        check("tmo_rdata",   32'(r), 32'h0);
        tick();
        check("tmo_then_idle", 32'(mem_en), 32'h0);

        // mem_ready on the last allowed cycle still succeeds
        run_access(1'b0, 8'h78, 1'b0, 16'h0, TMO - 1, 16'h1357, d, e, r);
        check("edge_done_at", 32'(d), 32'd5);
        check("edge_err",     32'(e), 32'h0);
        check("edge_rdata",   32'(r), 32'h1357);

        // Reset during the second ACCESS cycle
        a_req = 1'b1; a_addr = 8'h55; a_we = 1'b1; a_wdata = 16'h0F0F;
        tick();
        tick();
        check("mid_gnt_before", 32'(a_gnt), 32'h1);
        b_req = 1'b1; b_addr = 8'h66; b_we = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_a_gnt",   32'(a_gnt),   32'h0);
        check("mid_rst_mem_en",  32'(mem_en),  32'h0);
        check("mid_rst_mem_we",  32'(mem_we),  32'h0);
        check("mid_rst_b_rdata", 32'(b_rdata), 32'h0);
        for (int t = 0; t < 2; t++) begin
            tick();
            check("mid_rst_no_done", 32'(a_done), 32'h0);
        end
        rst_n = 1'b1;
        tick();
        check("post_rst_a_gnt", 32'(a_gnt), 32'h1);
        check("post_rst_b_gnt", 32'(b_gnt), 32'h0);
        mem_ready = 1'b1; mem_rdata = 16'h2468;
        tick();
        check("post_rst_a_done", 32'(a_done), 32'h1);
        a_req = 1'b0;
        tick();
        check("post_rst_b_gnt2", 32'(b_gnt), 32'h1);
        tick();
        b_req = 1'b0; mem_ready = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
